// File: rtl/rca_acc_pkg.sv
// Shared types and defaults for the ripple-carry stream accumulator.
package rca_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 8;

    // Two's-complement overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic aMsb, input logic bMsb, input logic sMsb);
        return (aMsb == bMsb) && (sMsb != aMsb);
    endfunction

endpackage

// File: rtl/acc_adder_core.sv
// Combinational WIDTH-bit ripple-carry adder used as the accumulator datapath.
module acc_adder_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic carry;

    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/rca_stream_accumulator.sv
// Streams operands through a ripple-carry adder into a running sum, then holds the result.
// Define SIGNED_OVF_EN to add the sticky signed-overflow output out_ovf.
module rca_stream_accumulator
    import rca_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
`ifdef SIGNED_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;

    logic [WIDTH-1:0] addSum;
    logic             addCarry;
    logic             carry_d;
    logic [CNT_W-1:0] count_d;
    logic             beatAccept;
    logic             clearStats;

    // The accumulator is always zero outside a stream, so the first beat needs no special path.
    acc_adder_core #(.WIDTH(WIDTH)) uAdder (
        .a     (acc_q),
        .b     (in_data),
        .c_in  (1'b0),
        .sum   (addSum),
        .c_out (addCarry)
    );

    always_comb begin
        in_ready   = (state_q != ST_HOLD) && !clear;
        beatAccept = in_valid && in_ready;
        clearStats = (state_q == ST_HOLD) ? out_ready : clear;
        carry_d    = carry_q | addCarry;
        count_d    = (count_q == '1) ? count_q : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else if (clearStats) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else if (beatAccept) begin
            state_q <= in_last ? ST_HOLD : ST_ACCUM;
            acc_q   <= addSum;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_carry = out_valid & carry_q;
    assign out_count = out_valid ? count_q : '0;

`ifdef SIGNED_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = ovf_q | add_ovf(acc_q[WIDTH-1], in_data[WIDTH-1], addSum[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset || clearStats) begin
            ovf_q <= 1'b0;
        end else if (beatAccept) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = out_valid & ovf_q;
`endif

endmodule

// File: tb/tb_rca_stream_accumulator.sv
// Scoreboard bench: a driver feeds operand streams into an arithmetic reference model,
// and an independent monitor checks every cycle of the result port against it.
module tb_rca_stream_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_carry;
    logic [7:0]  out_count;
`ifdef SIGNED_OVF_EN
    logic        out_ovf;
`endif

    rca_stream_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
`ifdef SIGNED_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        int          count;
        logic        ovf;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    bit          justPushed = 1'b0;
    int          readyMode = 1;

    // Reference model: running totals of the stream in progress.
    logic [31:0] mSum;
    logic        mCarry;
    int          mCount;
    logic        mOvf;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelClear();
        mSum   = '0;
        mCarry = 1'b0;
        mCount = 0;
        mOvf   = 1'b0;
    endtask

    task automatic modelBeat(input logic [31:0] d, input bit last);
        logic [32:0] full;
        full   = {1'b0, mSum} + {1'b0, d};
        mOvf   = mOvf | ((mSum[31] == d[31]) && (full[31] != d[31]));
        mCarry = mCarry | full[32];
        mSum   = full[31:0];
        mCount = (mCount >= 255) ? 255 : mCount + 1;
        if (last) begin
            expQ.push_back('{mSum, mCarry, mCount, mOvf});
            justPushed = 1'b1;
            modelClear();
        end
    endtask

    // One cycle of input drive; the model decides acceptance from its own notion of HOLD.
    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit l, input bit clr,
                                 output bit accepted);
        bit holding;
        bit expReady;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        clear    = clr;
        case (readyMode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        holding  = (expQ.size() != 0);
        expReady = !clr && !holding;
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expReady});
        accepted = v && expReady;
        if (clr && !holding) modelClear();
        else if (accepted) modelBeat(d, l);
    endtask

    task automatic idleCycle();
        bit acc;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic sendBeat(input logic [31:0] d, input bit l);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            applyStimulus(1'b1, d, l, 1'b0, acc);
            tries++;
        end
        if (!acc) checkOutput("beat_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        int n;
        readyMode = 1;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            idleCycle();
            n++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
        idleCycle();
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        justPushed = 1'b0;
        modelClear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: samples just before the next rising edge, when all drive for the cycle is settled.
    initial begin
        exp_t e;
        bit   expValid;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                justPushed = 1'b0;
            end else begin
                expValid   = (expQ.size() != 0) && !justPushed;
                justPushed = 1'b0;
                checkOutput("out_valid", {63'd0, out_valid}, {63'd0, expValid});
                if (out_valid && expValid) begin
                    e = expQ[0];
                    checkOutput("out_sum", {32'd0, out_sum}, {32'd0, e.sum});
                    checkOutput("out_carry", {63'd0, out_carry}, {63'd0, e.carry});
                    checkOutput("out_count", {56'd0, out_count}, 64'(e.count));
`ifdef SIGNED_OVF_EN
                    checkOutput("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
`endif
                    if (out_ready) void'(expQ.pop_front());
                end else if (!out_valid) begin
                    checkOutput("idle_sum", {32'd0, out_sum}, 64'd0);
                    checkOutput("idle_carry", {63'd0, out_carry}, 64'd0);
                    checkOutput("idle_count", {56'd0, out_count}, 64'd0);
`ifdef SIGNED_OVF_EN
                    checkOutput("idle_ovf", {63'd0, out_ovf}, 64'd0);
`endif
                end
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit acc;
        modelClear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idleCycle();

        $display("[TB] single-beat stream");
        sendBeat(32'h0000_0005, 1'b1);
        waitDrain();

        $display("[TB] carry-out stream");
        sendBeat(32'hFFFF_FFFF, 1'b0);
        sendBeat(32'h0000_0002, 1'b1);
        waitDrain();

        $display("[TB] backpressure in HOLD");
        readyMode = 0;
        sendBeat(32'h0000_1234, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0, (i == 2), acc);
        end
        waitDrain();

        $display("[TB] clear drops the concurrent beat");
        sendBeat(32'd10, 1'b0);
        sendBeat(32'd20, 1'b0);
        applyStimulus(1'b1, 32'd30, 1'b0, 1'b1, acc);
        sendBeat(32'd7, 1'b1);
        waitDrain();

        $display("[TB] count saturation");
        for (int i = 0; i < 300; i++) sendBeat(32'd1, (i == 299));
        waitDrain();

        $display("[TB] signed overflow and mid-stream reset");
        sendBeat(32'h7FFF_FFFF, 1'b0);
        sendBeat(32'h0000_0001, 1'b1);
        waitDrain();
        sendBeat(32'h0000_0100, 1'b0);
        sendBeat(32'h0000_0200, 1'b0);
        applyReset();
        sendBeat(32'd3, 1'b1);
        waitDrain();
        readyMode = 0;
        sendBeat(32'd9, 1'b1);
        idleCycle();
        idleCycle();
        applyReset();
        readyMode = 1;
        sendBeat(32'd4, 1'b0);
        sendBeat(32'h8000_0000, 1'b1);
        waitDrain();

        $display("[TB] randomized streams");
        for (int s = 0; s < 25; s++) begin
            int len;
            readyMode = 2;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                logic [31:0] d;
                if ($urandom_range(0, 3) == 0) idleCycle();
                if ($urandom_range(0, 11) == 0) applyStimulus(1'b1, $urandom, 1'b0, 1'b1, acc);
                d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
                sendBeat(d, (b == len - 1));
            end
        end
        waitDrain();

        repeat (3) idleCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
